vdbg_capture_ctrl: RTL
======================

# vdbg_capture_ctrl

Capture/readout controller for the video debug module's synchronous capture FIFO. It arms on a software command and waits for start-of-frame (optionally also a data trigger). It then writes a programmed number of 32-bit video beats into the FIFO and stops. Separately, it services single-word register reads by popping the FIFO. It sits between the video tap, the FIFO instance and the debug register bank, and owns the FIFO's write enable, read enable and clear.

## Interface
Parameters:
- `LEN_W`, 16: width of capture length and word counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `arm` in 1: single-cycle pulse; start a new capture.
- `abort` in 1: single-cycle pulse; stop the capture in progress.
- `cap_len` in LEN_W: words to capture; sampled on accepted `arm`.
- `trig_mask` in 32: trigger mask; only used with `VDBG_CAP_TRIGGER_EN`.
- `trig_value` in 32: trigger compare value; only used with `VDBG_CAP_TRIGGER_EN`.
- `vid_data` in 32: video tap data.
- `vid_valid` in 1: video beat valid.
- `vid_sof` in 1: start of frame; qualified by `vid_valid`.
- `fifo_din` out 32: FIFO write data.
- `fifo_we` out 1: FIFO write enable.
- `fifo_clr` out 1: FIFO synchronous reset.
- `fifo_full` in 1: FIFO full flag.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_oe` out 1: FIFO read enable (pop).
- `fifo_dout` in 32: FIFO read data; valid 1 cycle after `fifo_oe`.
- `rd_req` in 1: register read request, one pulse per word.
- `rd_data` out 32: read data.
- `rd_valid` out 1: `rd_data` valid, 1-cycle pulse.
- `busy` out 1: state is ARMED or CAPTURE.
- `done` out 1: state is DONE.
- `overflow` out 1: sticky; a beat was dropped because the FIFO was full.
- `word_cnt` out LEN_W: words written in the current capture.

## Operation
- Reset values:
  - State IDLE.
  - All outputs 0, including `fifo_din`, `rd_data`, `word_cnt` and `overflow`.
  - `fifo_clr` is 0; the FIFO receives `rst` separately.
- States: IDLE, ARMED, CAPTURE, DONE.
- **IDLE/DONE + `arm`:**
  - `fifo_clr` high for exactly 1 cycle; `cap_len` is latched.
  - `word_cnt` and `overflow` are cleared.
  - Next state is ARMED, or DONE if `cap_len` is 0.
- **`arm` in ARMED/CAPTURE:** ignored.
- **`abort` in ARMED/CAPTURE:** next state DONE; `word_cnt` is kept. `abort` is ignored in IDLE and DONE.
- **Same cycle `arm` and `abort`:** `abort` wins if the state is busy; `arm` wins otherwise.
- **ARMED:** waits for a beat with `vid_valid & vid_sof`. With the trigger compiled in, the beat must also meet the trigger condition. That beat is the first captured word, and the state moves to CAPTURE.
- **CAPTURE:** every `vid_valid` beat is captured. `vid_sof` is ignored after the first beat.
- **Capture write rules:**
  - Each captured beat registers `fifo_din <= vid_data` and asserts `fifo_we` for 1 cycle, with `fifo_full` low in the cycle the beat is sampled.
  - `word_cnt` increments on that same edge.
- **Ending a capture:**
  - When `word_cnt + 1 == latched cap_len`, the final write is issued and the state moves to DONE.
  - If `fifo_full` is high when a beat is sampled, no write is issued. `overflow` is set, `word_cnt` is unchanged, and the state moves to DONE.
- **Readout:**
  - Independent of capture state; allowed during CAPTURE.
  - `rd_req` with `fifo_empty` low asserts `fifo_oe` for 1 cycle, combinationally from `rd_req`.
  - The next cycle, `rd_valid` is 1 and `rd_data` = `fifo_dout`, latched.
  - `rd_req` with `fifo_empty` high: no pop. `rd_valid` still pulses the next cycle, with `rd_data` = 0xDEAD_0000.
  - Back-to-back `rd_req` on consecutive cycles are supported (one word per cycle).
- **Overlap:** `rd_req` in the same cycle as `fifo_clr` gets no pop and returns 0xDEAD_0000.
- **Widths:** `word_cnt` never wraps; it saturates at `cap_len` by construction.
- **Reset mid-operation:** `rst` aborts any state to IDLE next edge and drops any pending `rd_valid`.

## Timing
- `arm` at cycle N: `fifo_clr` and ARMED at N+1. Beats sampled from N+1 onward.
- Video beat sampled at edge E: `fifo_we`/`fifo_din` valid in cycle E+1, so write latency is 1 cycle.
- `rd_req` at cycle R: `fifo_oe` in R, `rd_valid` in R+1.
- `busy` and `done` are decoded from registered state.
- Throughput: 1 captured word per cycle and 1 read per cycle, concurrently.

## Configuration
- `VDBG_CAP_TRIGGER_EN` defined: ARMED leaves on a beat where `vid_sof` is high and `((vid_data ^ trig_value) & trig_mask) == 0`. A `vid_sof` beat that fails the compare is ignored, and the block waits for the next frame.
- Not defined: `trig_mask` and `trig_value` are unused, and the first valid `vid_sof` beat starts the capture.

## Test plan
- **Basic capture:** `cap_len`=4, arm, then frame with beats 0x10..0x17 → `fifo_we` on 4 cycles with 0x10..0x13, `word_cnt`=4, `done`=1, `overflow`=0.
- **Readout:** after the above, 5 `rd_req` pulses → `rd_data` 0x10, 0x11, 0x12, 0x13, then 0xDEAD_0000 with no pop.
- **Overflow:** `fifo_full` forced high after 2 writes, `cap_len`=8 → `word_cnt`=2, `overflow`=1, DONE, no third write.
- **Abort and re-arm:** abort in ARMED → DONE with `word_cnt`=0. Re-arm gives a 1-cycle `fifo_clr` and clears `overflow`. Arm while busy is ignored.
- **Trigger:** with `VDBG_CAP_TRIGGER_EN`, mask 0xFF, value 0x42. A SOF beat of 0x41 is skipped; a SOF beat of 0x142 starts the capture. `cap_len`=0 arm goes straight to DONE.
- **Reset mid-capture:** `rst` in CAPTURE → IDLE and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/vdbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vdbg_capture_ctrl
// Purpose  : Capture/readout controller for the video debug capture FIFO.
//            Arms on a software pulse, waits for start-of-frame (optionally
//            qualified by a masked data trigger), then writes a programmed
//            number of 32-bit video beats into the FIFO. Independently pops
//            single words for register reads.
// Config   : define VDBG_CAP_TRIGGER_EN to qualify the SOF beat with
//            ((vid_data ^ trig_value) & trig_mask) == 0.
// Ports    : clk, rst (sync, active-high)
//            arm, abort, cap_len      - software control
//            trig_mask, trig_value    - trigger compare (optional feature)
//            vid_data/valid/sof       - video tap
//            fifo_din/we/clr/oe       - FIFO control (owned here)
//            fifo_full/empty/dout     - FIFO status and read data
//            rd_req, rd_data/valid    - register read port
//            busy, done, overflow, word_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module vdbg_capture_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [LEN_W-1:0] cap_len,
  input  logic [31:0]      trig_mask,
  input  logic [31:0]      trig_value,
  input  logic [31:0]      vid_data,
  input  logic             vid_valid,
  input  logic             vid_sof,
  output logic [31:0]      fifo_din,
  output logic             fifo_we,
  output logic             fifo_clr,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_oe,
  input  logic [31:0]      fifo_dout,
  input  logic             rd_req,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LEN_W-1:0] word_cnt
);

  localparam logic [31:0] C_EMPTY_WORD = 32'hDEAD_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_cap_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic             r_overflow;
  logic [31:0]      r_fifo_din;
  logic             r_fifo_we;
  logic             r_fifo_clr;
  logic             r_rd_valid;
  logic             r_rd_popped;
  logic [31:0]      r_rd_hold;

  logic             w_busy;
  logic             w_arm_ok;
  logic             w_abort_ok;
  logic             w_trig_ok;
  logic             w_beat;
  logic             w_write;
  logic             w_drop;
  logic             w_pop;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [31:0]      w_rd_word;

`ifdef VDBG_CAP_TRIGGER_EN
  assign w_trig_ok = (((vid_data ^ trig_value) & trig_mask) == 32'h0);
`else
  // Trigger inputs are part of the fixed port list but have no function here.
  logic w_unused_trig;
  assign w_unused_trig = ^{trig_mask, trig_value};
  assign w_trig_ok     = 1'b1;
`endif

  assign w_busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  // arm only counts when not busy; abort only when busy, so they never collide.
  assign w_arm_ok   = arm & ~w_busy;
  assign w_abort_ok = abort & w_busy;
  assign w_cnt_inc  = r_word_cnt + LEN_W'(1);

  // A beat is consumed either as the triggering SOF beat in ARMED or as any
  // valid beat in CAPTURE. An abort in the same cycle discards the beat.
  assign w_beat  = ~w_abort_ok & vid_valid &
                   (((r_state == ST_ARMED) & vid_sof & w_trig_ok) |
                    (r_state == ST_CAPTURE));
  assign w_write = w_beat & ~fifo_full;
  assign w_drop  = w_beat & fifo_full;

  // Pop is suppressed while the FIFO is being cleared: the word would vanish.
  assign w_pop   = rd_req & ~fifo_empty & ~r_fifo_clr & ~rst;

  always_comb begin
    w_next_state = r_state;
    if (w_arm_ok) begin
      w_next_state = (cap_len == '0) ? ST_DONE : ST_ARMED;
    end else if (w_abort_ok || w_drop) begin
      w_next_state = ST_DONE;
    end else if (w_write) begin
      w_next_state = (w_cnt_inc == r_cap_len) ? ST_DONE : ST_CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cap_len   <= '0;
      r_word_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_fifo_din  <= '0;
      r_fifo_we   <= 1'b0;
      r_fifo_clr  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_popped <= 1'b0;
      r_rd_hold   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_fifo_we   <= w_write;
      r_fifo_clr  <= w_arm_ok;
      r_rd_valid  <= rd_req;
      r_rd_popped <= w_pop;
      if (r_rd_valid) begin
        r_rd_hold <= w_rd_word;
      end
      if (w_arm_ok) begin
        r_cap_len  <= cap_len;
        r_word_cnt <= '0;
        r_overflow <= 1'b0;
      end
      if (w_write) begin
        r_fifo_din <= vid_data;
        r_word_cnt <= w_cnt_inc;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO read data appears the cycle after the pop, so the returned word is
  // taken straight from fifo_dout in the rd_valid cycle and then held.
  assign w_rd_word = r_rd_popped ? fifo_dout : C_EMPTY_WORD;
  assign rd_data   = r_rd_valid ? w_rd_word : r_rd_hold;
  assign rd_valid  = r_rd_valid;

  assign fifo_oe   = w_pop;
  assign fifo_din  = r_fifo_din;
  assign fifo_we   = r_fifo_we;
  assign fifo_clr  = r_fifo_clr;
  assign busy      = w_busy;
  assign done      = (r_state == ST_DONE);
  assign overflow  = r_overflow;
  assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire
